// File: rtl/digdug_spatram.sv
// Sprite-attribute RAM for the DigDug video block: CPU-side back buffer (three 8-bit planes),
// video-side 24-bit front buffer refreshed by a copy engine at each vertical-blank rise.
module digdug_spatram #(
  parameter bit AUTOCOPY = 1'b1
) (
  input  logic        CLK48M,
  input  logic        RST_N,
  input  logic [1:0]  CPUSEL,
  input  logic [6:0]  CPUAD,
  input  logic        CPUWE,
  input  logic [7:0]  CPUDI,
  output logic [7:0]  CPUDO,
  input  logic        VBLK,
  input  logic        SPATCL,
  input  logic [6:0]  SPATAD,
  output logic [23:0] SPATDT,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  logic [7:0]  plane0 [0:127];
  logic [7:0]  plane1 [0:127];
  logic [7:0]  plane2 [0:127];
  logic [23:0] front  [0:127];

  state_t      state, state_nx;
  logic [6:0]  idx;
  logic        copy_rd, copy_wr;
  logic [23:0] copy_p0;
  logic        spcl_d, vb_d;
  logic        vid_pulse, copy_start;
  logic        vld_p0;
  logic [23:0] back_cat;

  assign vid_pulse  = SPATCL & ~spcl_d;
  assign copy_start = VBLK & ~vb_d & AUTOCOPY;
  assign back_cat   = {plane2[SPATAD], plane1[SPATAD], plane0[SPATAD]};

  // Storage: CPU write port, copy-engine read into copy_p0, copy-engine write to front
  always_ff @(posedge CLK48M) begin
    if (CPUWE) begin
      case (CPUSEL)
        2'd0:    plane0[CPUAD] <= CPUDI;
        2'd1:    plane1[CPUAD] <= CPUDI;
        2'd2:    plane2[CPUAD] <= CPUDI;
        default: ;
      endcase
    end
    if (copy_rd) copy_p0 <= {plane2[idx], plane1[idx], plane0[idx]};
    if (copy_wr) front[idx] <= copy_p0;
  end

  // CPU read port: one-cycle latency, old data on a same-cycle write
  always_ff @(posedge CLK48M or negedge RST_N) begin
    if (!RST_N) begin
      CPUDO <= 8'h00;
    end else begin
      case (CPUSEL)
        2'd0:    CPUDO <= plane0[CPUAD];
        2'd1:    CPUDO <= plane1[CPUAD];
        2'd2:    CPUDO <= plane2[CPUAD];
        default: CPUDO <= 8'h00;
      endcase
    end
  end

  // p0: edge detect on SPATCL/VBLK; p1: video read lands in SPATDT
  always_ff @(posedge CLK48M or negedge RST_N) begin
    if (!RST_N) begin
      spcl_d <= 1'b0;
      vb_d   <= 1'b0;
      vld_p0 <= 1'b0;
      SPATDT <= 24'h0;
    end else begin
      spcl_d <= SPATCL;
      vb_d   <= VBLK;
      vld_p0 <= vid_pulse;
      if (vld_p0) SPATDT <= AUTOCOPY ? front[SPATAD] : back_cat;
    end
  end

  // Copy FSM: state register and entry index
  always_ff @(posedge CLK48M or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      idx   <= 7'd0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && copy_start)
        idx <= 7'd0;
      else if (state == S_WRITE && idx != 7'd127)
        idx <= idx + 7'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (copy_start) state_nx = S_READ;
      S_READ:  state_nx = S_WRITE;
      S_WRITE: state_nx = (idx == 7'd127) ? S_IDLE : S_READ;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY    = 1'b0;
    copy_rd = 1'b0;
    copy_wr = 1'b0;
    case (state)
      S_READ:  begin BUSY = 1'b1; copy_rd = 1'b1; end
      S_WRITE: begin BUSY = 1'b1; copy_wr = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: doc/digdug_spatram.md
# digdug_spatram

Sprite-attribute memory that serves the sprite scanline generator inside the DigDug video block. It holds the 128 sprite entries written byte-wise by the CPU in three 8-bit planes. Each entry is a 24-bit word assembled as {plane2, plane1, plane0}. The block keeps a CPU-side back buffer and a video-side front buffer, copies back to front once per frame at the start of vertical blank, and answers the video block's SPATCL/SPATAD read requests with a registered 24-bit SPATDT.

## Interface

Parameters:
- AUTOCOPY, 1: 1 = double-buffered with a copy at each VBLK rise; 0 = video reads the back buffer directly and the copy FSM is disabled.

Ports:
- CLK48M  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CPUSEL  in  2  plane select: 0..2 = plane0..plane2, 3 = unmapped.
- CPUAD  in  7  entry index.
- CPUWE  in  1  write strobe, one byte per cycle while high.
- CPUDI  in  8  write data.
- CPUDO  out  8  read data for CPUSEL/CPUAD, registered from the back buffer.
- VBLK  in  1  vertical blank flag from the video block; its rising edge starts a copy.
- SPATCL  in  1  video read strobe, a divided clock generated from CLK48M.
- SPATAD  in  7  video entry index.
- SPATDT  out  24  entry data {plane2, plane1, plane0}.
- BUSY  out  1  high while a copy is in progress.

## Operation

- Storage:
  - Back buffer: three 128x8 planes, each with a CPU read/write port and a copy-engine read port.
  - Front buffer: 128x24, with one write port (copy engine) and one read port (video).
  - The RAMs are not cleared by reset.
- CPU write: when CPUWE=1 and CPUSEL<3, plane[CPUSEL][CPUAD] <= CPUDI in that cycle. With CPUSEL=3 the write is dropped.
- CPU read: CPUDO <= plane[CPUSEL][CPUAD] every cycle, or 8'h00 when CPUSEL=3. A write and a read to the same location in the same cycle return the old data.
- Edge detectors: SPATCL and VBLK are each registered once in CLK48M (spcl_d, vb_d).
  - Video read pulse: SPATCL & ~spcl_d.
  - Copy start pulse: VBLK & ~vb_d.
- Video read: on a video read pulse, SPATDT <= front[SPATAD], or the back buffer concatenation when AUTOCOPY=0. SPATDT holds its value between pulses.
- Copy FSM, 2-bit state:
  - IDLE: BUSY=0. A copy start pulse with AUTOCOPY=1 sets idx=0 and moves to READ.
  - READ: issue a back-buffer read of all three planes at idx, then go to WRITE.
  - WRITE: front[idx] <= {p2,p1,p0}. If idx=127, go to IDLE; otherwise idx <= idx+1 and go to READ.
  - One full copy takes 256 cycles. BUSY=1 in READ and WRITE.
- Collisions:
  - A copy start pulse while BUSY is ignored; there is no restart and no queue.
  - A CPU write during a copy to an index that has already been copied reaches the front buffer only at the next frame. A write to an index not yet copied is picked up in the current copy.
  - A video read of the index being written in the same cycle returns the old front data.
- Reset mid-copy: FSM returns to IDLE and idx=0. The partially copied front contents are kept.
- Reset values: SPATDT=24'h0, CPUDO=8'h0, BUSY=0, state=IDLE, idx=0, spcl_d=0, vb_d=0.

## Timing

- CPU read latency: 1 cycle. CPUDO is valid in the cycle after the address is presented.
- CPU write: takes effect in the same cycle. Issuing a copy-port read of that location in the following cycle returns the new data.
- Video read: if SPATCL rises before clock edge n (so the pulse is seen at edge n), SPATDT is valid after edge n+1, i.e. 2 CLK48M cycles after SPATCL is sampled high.
  - SPATAD must be stable from the edge that samples SPATCL high through the next edge.
  - SPATCL has a minimum period of 4 CLK48M cycles.
- Copy: BUSY rises at the edge after the start pulse is detected and stays high for exactly 256 cycles. front[k] is updated at cycle 2k+2 after the start pulse.
- Frame budget: the copy finishes well inside VBLK; the video block holds VBLK for 64 pixel clocks, i.e. at least 512 CLK48M cycles.
- Throughput: one CPU access per cycle with no wait states. The CPU is never stalled by the copy.

## Test plan

- Reset then idle: RST_N low for 3 cycles with random inputs -> SPATDT=0, CPUDO=0, BUSY=0. Assert RST_N low mid-copy at idx=40 -> BUSY drops asynchronously and does not rise again without a new VBLK edge.
- CPU write/readback: write plane0[5]=8'hA1, plane1[5]=8'hB2, plane2[5]=8'hC3; read each back -> CPUDO A1, B2, C3 one cycle after each address. CPUSEL=3 -> CPUDO=00 and no RAM changes.
- Copy and video read: after the writes above, pulse VBLK -> BUSY high for 256 cycles. Then SPATCL rise with SPATAD=5 -> SPATDT=24'hC3B2A1 two cycles later. A video read of index 5 before the copy -> old front value.
- Mid-copy CPU write: during a copy, write plane0[2]=8'h11 at idx=10 and plane0[100]=8'h22 at idx=10 -> afterwards front[2][7:0] is unchanged and front[100][7:0]=8'h22.
- Retrigger: a second VBLK rise at cycle 50 of a copy -> ignored. BUSY still falls at cycle 256 and the next VBLK starts a fresh copy.
- AUTOCOPY=0: write plane2[127]=8'h7E -> the next SPATCL read of index 127 returns 8'h7E in bits [23:16] with no VBLK needed; BUSY stays 0 through VBLK edges.
